// File: rtl/ssc_dsd_decode_ctrl.sv
// ssc_dsd_decode_ctrl
//   Sequencing controller for the SSC-DSD (39 x 8-bit symbol) decoder. Accepts one
//   312-bit codeword per handshake and walks it through the external syndrome
//   generator and error-information datapath. It then applies the single-symbol
//   correction and returns 288 data bits with an NE/CE/DUE result. It also keeps
//   saturating CE and DUE counters.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     codeword handshake, in_cw = symbols 0..38 (8 bits each)
//   syn_cw                registered codeword to the syndrome generator
//   syn_s0/s1/s2          syndromes returned combinationally from syn_cw
//   ei_s0/s1/s2           registered syndromes to the error-information datapath
//   ei_loc/ei_val/ei_res  error location, error value and classification returned
//   out_valid/out_ready   result handshake; out_data = symbols 0..35, out_res
//   cnt_clr               synchronous clear of ce_cnt/due_cnt
//   ce_cnt/due_cnt        saturating corrected / uncorrectable counts
module ssc_dsd_decode_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          DUE_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [311:0]     in_cw,
    output logic [311:0]     syn_cw,
    input  logic [7:0]       syn_s0,
    input  logic [7:0]       syn_s1,
    input  logic [7:0]       syn_s2,
    output logic [7:0]       ei_s0,
    output logic [7:0]       ei_s1,
    output logic [7:0]       ei_s2,
    input  logic [5:0]       ei_loc,
    input  logic [7:0]       ei_val,
    input  logic [1:0]       ei_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [287:0]     out_data,
    output logic [1:0]       out_res,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] due_cnt
);

    localparam int unsigned DATA_W   = 288;
    localparam int unsigned LOC_W    = 6;
    localparam int unsigned SYM_W    = 8;
    localparam logic [LOC_W-1:0] LAST_DATA_SYM = 6'd35;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYND  = 3'd1;
    localparam logic [2:0] ST_EINFO = 3'd2;
    localparam logic [2:0] ST_CORR  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [LOC_W-1:0]  loc_q;
    logic [SYM_W-1:0]  val_q;
    logic [1:0]        res_q;
    logic              accept_c;
    logic              is_ce_c;
    logic              is_due_c;
    logic [DATA_W-1:0] corr_data_c;

    assign accept_c = in_valid && in_ready;
    assign is_ce_c  = (res_q == 2'b01);
    assign is_due_c = res_q[1];     // 10 and 11 both classify as DUE

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: strictly one codeword in flight
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept_c) state_nxt = ST_SYND;
            ST_SYND:  state_nxt = ST_EINFO;
            ST_EINFO: state_nxt = ST_CORR;
            ST_CORR:  state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Correction: flip one data symbol; parity-symbol errors leave data untouched
    always_comb begin
        corr_data_c = syn_cw[DATA_W-1:0];
        if (is_ce_c && (loc_q <= LAST_DATA_SYM)) begin
            corr_data_c = corr_data_c ^ (DATA_W'(val_q) << {loc_q, 3'b000});
        end else if (is_due_c && DUE_ZERO) begin
            corr_data_c = '0;
        end
    end

    // Handshake flags are registered copies of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_OUT);
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_cw   <= '0;
            ei_s0    <= '0;
            ei_s1    <= '0;
            ei_s2    <= '0;
            loc_q    <= '0;
            val_q    <= '0;
            res_q    <= '0;
            out_data <= '0;
            out_res  <= '0;
        end else begin
            if (state == ST_IDLE && accept_c) begin
                syn_cw <= in_cw;
            end
            if (state == ST_SYND) begin
                ei_s0 <= syn_s0;
                ei_s1 <= syn_s1;
                ei_s2 <= syn_s2;
            end
            if (state == ST_EINFO) begin
                loc_q <= ei_loc;
                val_q <= ei_val;
                res_q <= ei_res;
            end
            if (state == ST_CORR) begin
                out_data <= corr_data_c;
                out_res  <= is_due_c ? 2'b10 : res_q;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt  <= '0;
            due_cnt <= '0;
        end else if (cnt_clr) begin
            ce_cnt  <= '0;
            due_cnt <= '0;
        end else if (state == ST_CORR) begin
            if (is_ce_c && !(&ce_cnt)) begin
                ce_cnt <= ce_cnt + CNT_W'(1);
            end
            if (is_due_c && !(&due_cnt)) begin
                due_cnt <= due_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ssc_dsd_decode_ctrl.sv
module tb_ssc_dsd_decode_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [311:0] in_cw;
    logic [311:0] syn_cw;
    logic [7:0]   syn_s0, syn_s1, syn_s2;
    logic [7:0]   ei_s0, ei_s1, ei_s2;
    logic [5:0]   ei_loc;
    logic [7:0]   ei_val;
    logic [1:0]   ei_res;
    logic         out_valid;
    logic         out_ready;
    logic [287:0] out_data;
    logic [1:0]   out_res;
    logic         cnt_clr;
    logic [1:0]   ce_cnt, due_cnt;

    typedef struct {
        logic [287:0] d;
        logic [1:0]   r;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ce_m   = 0;
    int   due_m  = 0;

    ssc_dsd_decode_ctrl #(.CNT_W(2), .DUE_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .syn_cw(syn_cw), .syn_s0(syn_s0), .syn_s1(syn_s1), .syn_s2(syn_s2),
        .ei_s0(ei_s0), .ei_s1(ei_s1), .ei_s2(ei_s2),
        .ei_loc(ei_loc), .ei_val(ei_val), .ei_res(ei_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_res(out_res),
        .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .due_cnt(due_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [311:0] act, input logic [311:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every accepted result is popped and compared
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got res %0h expected no result", out_res);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", 312'(out_data), 312'(mon_e.d));
                chk("out_res", 312'(out_res), 312'(mon_e.r));
            end
        end
    end

    // Symbol k = seed + k
    function automatic logic [311:0] mk_cw(input logic [7:0] seed);
        logic [311:0] c;
        for (int k = 0; k < 39; k++) c[8*k +: 8] = seed + 8'(k);
        return c;
    endfunction

    // Entered at posedge+#1; returns at accept edge + #1
    task automatic send(input logic [311:0] cw, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [5:0] loc, input logic [7:0] val,
                        input logic [1:0] res, input logic [287:0] ed, input logic [1:0] er,
                        input bit push);
        int n = 0;
        exp_t e;
        in_cw = cw; syn_s0 = s0; syn_s1 = s1; syn_s2 = s2;
        ei_loc = loc; ei_val = val; ei_res = res;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.d = ed; e.r = er;
            q.push_back(e);
            if (res == 2'b01 && ce_m < 3) ce_m++;
            if (res[1] && due_m < 3) due_m++;
        end
    endtask

    task automatic wait_out(input int exp_lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 312'(n), 312'(exp_lat));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_after", 312'(in_ready), 312'(1));
        chk("ce_cnt", 312'(ce_cnt), 312'(ce_m));
        chk("due_cnt", 312'(due_cnt), 312'(due_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        logic [311:0] cw;
        logic [287:0] ed;
        bit           seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        in_cw = '0; syn_s0 = '0; syn_s1 = '0; syn_s2 = '0;
        ei_loc = '0; ei_val = '0; ei_res = '0;
        #12;
        chk("rst_in_ready", 312'(in_ready), 312'(1));
        chk("rst_out_valid", 312'(out_valid), 312'(0));
        chk("rst_out_res", 312'(out_res), 312'(0));
        chk("rst_out_data", 312'(out_data), 312'(0));
        chk("rst_syn_cw", syn_cw, 312'(0));
        chk("rst_ei_s0", 312'(ei_s0), 312'(0));
        chk("rst_ce_cnt", 312'(ce_cnt), 312'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // NE with A5 pattern
        cw = {39{8'hA5}};
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h00, 2'b00, {36{8'hA5}}, 2'b00, 1'b1);
        chk("syn_cw", syn_cw, cw);
        chk("in_ready_busy", 312'(in_ready), 312'(0));
        wait_out(3);
        wait_idle();

        // CE at symbol 5: 0x0A ^ 0x3C = 0x36
        cw = mk_cw(8'h05);
        ed = cw[287:0]; ed[47:40] = 8'h36;
        send(cw, 8'h11, 8'h22, 8'h33, 6'd5, 8'h3C, 2'b01, ed, 2'b01, 1'b1);
        wait_out(3);
        chk("ei_s0", 312'(ei_s0), 312'(8'h11));
        chk("ei_s1", 312'(ei_s1), 312'(8'h22));
        chk("ei_s2", 312'(ei_s2), 312'(8'h33));
        wait_idle();

        // CE in parity symbol 37: data untouched
        cw = mk_cw(8'h40);
        send(cw, 8'h01, 8'h02, 8'h03, 6'd37, 8'hFF, 2'b01, cw[287:0], 2'b01, 1'b1);
        wait_out(3); wait_idle();

        // DUE and reserved 11: zeroed data
        cw = mk_cw(8'h80);
        send(cw, 8'h7E, 8'h00, 8'h01, 6'd3, 8'h55, 2'b10, 288'd0, 2'b10, 1'b1);
        wait_out(3); wait_idle();
        send(cw, 8'h7E, 8'h00, 8'h01, 6'd9, 8'h55, 2'b11, 288'd0, 2'b10, 1'b1);
        wait_out(3); wait_idle();

        // Backpressure: 7 stalled cycles with a new codeword pending
        out_ready = 1'b0;
        cw = mk_cw(8'hC0);
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h00, 2'b00, cw[287:0], 2'b00, 1'b1);
        wait_out(3);
        in_cw = mk_cw(8'hE0); in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 312'(out_valid), 312'(1));
            chk("bp_out_data", 312'(out_data), 312'(cw[287:0]));
            chk("bp_in_ready", 312'(in_ready), 312'(0));
        end
        out_ready = 1'b1;
        cw = mk_cw(8'hE0);
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h00, 2'b00, cw[287:0], 2'b00, 1'b1);
        wait_out(3); wait_idle();

        // Two more CEs: 2-bit ce_cnt saturates at 3; symbol 0 = 0x10 ^ 0x01 = 0x11
        cw = mk_cw(8'h10);
        ed = cw[287:0]; ed[7:0] = 8'h11;
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h01, 2'b01, ed, 2'b01, 1'b1);
        wait_out(3); wait_idle();
        ed = cw[287:0]; ed[287:280] = 8'h33 ^ 8'h80;   // symbol 35 = 0x10+35 = 0x33
        send(cw, 8'h00, 8'h00, 8'h00, 6'd35, 8'h80, 2'b01, ed, 2'b01, 1'b1);
        wait_out(3); wait_idle();
        chk("ce_sat", 312'(ce_cnt), 312'(3));

        // cnt_clr in the CORR cycle beats the increment
        ed = cw[287:0]; ed[7:0] = 8'h11;
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h01, 2'b01, ed, 2'b01, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        ce_m = 0; due_m = 0;
        chk("clr_out_valid", 312'(out_valid), 312'(1));
        wait_idle();

        // One DUE so the reset below has a count to clear
        cw = mk_cw(8'h20);
        send(cw, 8'h00, 8'h00, 8'h00, 6'd0, 8'h00, 2'b10, 288'd0, 2'b10, 1'b1);
        wait_out(3); wait_idle();

        // Reset while in EINFO: no result, counters cleared
        send(cw, 8'h00, 8'h00, 8'h00, 6'd4, 8'h0F, 2'b01, 288'd0, 2'b01, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        ce_m = 0; due_m = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 312'(seen), 312'(0));
        chk("abort_in_ready", 312'(in_ready), 312'(1));
        chk("abort_ce_cnt", 312'(ce_cnt), 312'(0));
        chk("abort_due_cnt", 312'(due_cnt), 312'(0));

        chk("scoreboard_empty", 312'(q.size()), 312'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
